// File: rtl/issue_ctrl_pkg.sv
// ============================================================================
// Module      : issue_ctrl_pkg
// Description : Register-index types, defaults and holding-register states
//               shared by the issue controller and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_ctrl_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int REG_W        = $clog2(NUM_REGS_DEF);

    typedef logic [REG_W-1:0] rs1_t;
    typedef logic [REG_W-1:0] rs2_t;
    typedef logic [REG_W-1:0] rd_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } iss_state_t;

    // x0 is hardwired zero and never tracked
    function automatic logic is_tracked(input rd_t r);
        return (r != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// ============================================================================
// Module      : issue_scoreboard
// Description : Busy-register scoreboard with outstanding-write counter and
//               RAW/WAW/capacity hazard detection. Optional macro
//               WB_BYPASS_EN applies the same-cycle writeback to the check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS        = NUM_REGS_DEF,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_set,
    input  rd_t  i_set_rd,
    input  logic i_clr,
    input  rd_t  i_clr_rd,
    input  rs1_t i_rs1,
    input  logic i_rd1,
    input  rs2_t i_rs2,
    input  logic i_rd2,
    input  rd_t  i_rd,
    input  logic i_wr,
    output logic o_hazard,
    output logic o_busy_any
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_count;
    logic [NUM_REGS-1:0] w_busy_eff;
    logic [CNT_W-1:0]    w_count_eff;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_set_en;
    logic                w_clr_hit;
    logic                w_raw;
    logic                w_waw;
    logic                w_cap;

    assign w_set_en  = i_set & is_tracked(i_set_rd);
    assign w_clr_hit = i_clr & r_busy[i_clr_rd];

    always_comb begin
        w_busy_eff  = r_busy;
        w_count_eff = r_count;
`ifdef WB_BYPASS_EN
        if (w_clr_hit) begin
            w_busy_eff[i_clr_rd] = 1'b0;
            w_count_eff          = r_count - CNT_W'(1);
        end
`endif
    end

    assign w_raw    = (i_rd1 & w_busy_eff[i_rs1]) | (i_rd2 & w_busy_eff[i_rs2]);
    assign w_waw    = i_wr & w_busy_eff[i_rd];
    assign w_cap    = i_wr & is_tracked(i_rd) & (w_count_eff == CNT_W'(MAX_OUTSTANDING));
    assign o_hazard = w_raw | w_waw | w_cap;

    // Clear first, then set, so a same-register set survives
    always_comb begin
        w_busy_next = r_busy;
        if (w_clr_hit) begin
            w_busy_next[i_clr_rd] = 1'b0;
        end
        if (w_set_en) begin
            w_busy_next[i_set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy <= w_busy_next;
            case ({w_set_en, w_clr_hit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_busy_any = |r_busy;

endmodule

`default_nettype wire

// File: rtl/issue_ctrl.sv
// ============================================================================
// Module      : issue_ctrl
// Description : In-order issue controller: one-entry holding register with
//               valid/ready handshakes, stalled by the scoreboard hazards.
//               Optional macro WB_BYPASS_EN (inside issue_scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS        = NUM_REGS_DEF,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PAYLOAD_W       = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dec_valid_i,
    output logic                 dec_ready_o,
    input  rs1_t                 dec_rs1_i,
    input  logic                 dec_rd1_i,
    input  rs2_t                 dec_rs2_i,
    input  logic                 dec_rd2_i,
    input  rd_t                  dec_rd_i,
    input  logic                 dec_wr_i,
    input  logic [PAYLOAD_W-1:0] dec_payload_i,
    output logic                 iss_valid_o,
    input  logic                 iss_ready_i,
    output rs1_t                 iss_rs1_o,
    output logic                 iss_rd1_o,
    output rs2_t                 iss_rs2_o,
    output logic                 iss_rd2_o,
    output rd_t                  iss_rd_o,
    output logic                 iss_wr_o,
    output logic [PAYLOAD_W-1:0] iss_payload_o,
    input  logic                 wb_valid_i,
    input  rd_t                  wb_rd_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic                 sb_busy_o
);

    iss_state_t           r_state;
    rs1_t                 r_rs1;
    logic                 r_rd1;
    rs2_t                 r_rs2;
    logic                 r_rd2;
    rd_t                  r_rd;
    logic                 r_wr;
    logic [PAYLOAD_W-1:0] r_payload;

    logic w_full;
    logic w_hazard;
    logic w_issue;
    logic w_accept;

    issue_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_set      (w_issue & r_wr),
        .i_set_rd   (r_rd),
        .i_clr      (wb_valid_i),
        .i_clr_rd   (wb_rd_i),
        .i_rs1      (r_rs1),
        .i_rd1      (r_rd1),
        .i_rs2      (r_rs2),
        .i_rd2      (r_rd2),
        .i_rd       (r_rd),
        .i_wr       (r_wr),
        .o_hazard   (w_hazard),
        .o_busy_any (sb_busy_o)
    );

    assign w_full      = (r_state == FULL);
    assign iss_valid_o = ~rst_i & w_full & ~w_hazard & ~flush_i;
    assign w_issue     = iss_valid_o & iss_ready_i;
    assign dec_ready_o = ~rst_i & (~w_full | w_issue);
    // Flush discards both the held entry and any same-cycle accept
    assign w_accept    = dec_valid_i & dec_ready_o & ~flush_i;
    assign stall_o     = ~rst_i & w_full & ~iss_valid_o & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= EMPTY;
            r_rs1     <= '0;
            r_rd1     <= 1'b0;
            r_rs2     <= '0;
            r_rd2     <= 1'b0;
            r_rd      <= '0;
            r_wr      <= 1'b0;
            r_payload <= '0;
        end else if (flush_i) begin
            r_state <= EMPTY;
        end else if (w_accept) begin
            r_state   <= FULL;
            r_rs1     <= dec_rs1_i;
            r_rd1     <= dec_rd1_i;
            r_rs2     <= dec_rs2_i;
            r_rd2     <= dec_rd2_i;
            r_rd      <= dec_rd_i;
            r_wr      <= dec_wr_i;
            r_payload <= dec_payload_i;
        end else if (w_issue) begin
            r_state <= EMPTY;
        end
    end

    assign iss_rs1_o     = r_rs1;
    assign iss_rd1_o     = r_rd1;
    assign iss_rs2_o     = r_rs2;
    assign iss_rd2_o     = r_rd2;
    assign iss_rd_o      = r_rd;
    assign iss_wr_o      = r_wr;
    assign iss_payload_o = r_payload;

endmodule

`default_nettype wire

// File: tb/tb_issue_ctrl.sv
// ============================================================================
// Module      : tb_issue_ctrl
// Description : Self-checking bench for issue_ctrl: directed vector tables
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_ctrl;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit        rst, dv;
        bit [4:0]  rs1;
        bit        r1;
        bit [4:0]  rs2;
        bit        r2;
        bit [4:0]  rd;
        bit        wr;
        bit [63:0] pay;
        bit        ir, wbv;
        bit [4:0]  wbrd;
        bit        fl;
        bit        e_iv, e_dr, e_st, e_sb;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i, dec_valid_i, dec_ready_o, dec_rd1_i, dec_rd2_i, dec_wr_i;
    logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i, wb_rd_i;
    logic [63:0] dec_payload_i, iss_payload_o;
    logic        iss_valid_o, iss_ready_i, iss_rd1_o, iss_rd2_o, iss_wr_o;
    logic [4:0]  iss_rs1_o, iss_rs2_o, iss_rd_o;
    logic        wb_valid_i, flush_i, stall_o, sb_busy_o;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit        m_full;
    bit [4:0]  m_rs1, m_rs2, m_rd;
    bit        m_r1, m_r2, m_wr;
    bit [63:0] m_pay;
    bit [31:0] m_busy;
    int        m_cnt;
    bit        x_iv, x_dr, x_st, x_issue;

    always #5 clk_i = ~clk_i;

    issue_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rs1_i(dec_rs1_i), .dec_rd1_i(dec_rd1_i),
        .dec_rs2_i(dec_rs2_i), .dec_rd2_i(dec_rd2_i),
        .dec_rd_i(dec_rd_i), .dec_wr_i(dec_wr_i), .dec_payload_i(dec_payload_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_rs1_o(iss_rs1_o), .iss_rd1_o(iss_rd1_o),
        .iss_rs2_o(iss_rs2_o), .iss_rd2_o(iss_rd2_o),
        .iss_rd_o(iss_rd_o), .iss_wr_o(iss_wr_o), .iss_payload_o(iss_payload_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .flush_i(flush_i), .stall_o(stall_o), .sb_busy_o(sb_busy_o)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_eval(input vec_t v);
        bit [31:0] eb;
        int        ec;
        bit        raw, waw, cap;
        eb = m_busy;
        ec = m_cnt;
`ifdef WB_BYPASS_EN
        if (v.wbv && m_busy[v.wbrd]) begin
            eb[v.wbrd] = 1'b0;
            ec = ec - 1;
        end
`endif
        raw     = (m_r1 && eb[m_rs1]) || (m_r2 && eb[m_rs2]);
        waw     = m_wr && eb[m_rd];
        cap     = m_wr && (m_rd != 0) && (ec == 4);
        x_iv    = !v.rst && m_full && !raw && !waw && !cap && !v.fl;
        x_issue = x_iv && v.ir;
        x_dr    = !v.rst && (!m_full || x_issue);
        x_st    = !v.rst && m_full && !x_iv && !v.fl;
    endtask

    task automatic model_update(input vec_t v);
        if (v.rst) begin
            m_full = 0; m_busy = '0; m_cnt = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_r1 = 0; m_r2 = 0; m_wr = 0; m_pay = '0;
        end else begin
            if (v.wbv && m_busy[v.wbrd]) begin
                m_busy[v.wbrd] = 1'b0;
                m_cnt = m_cnt - 1;
            end
            if (x_issue && m_wr && m_rd != 0) begin
                m_busy[m_rd] = 1'b1;
                m_cnt = m_cnt + 1;
            end
            if (v.fl) begin
                m_full = 0;
            end else if (v.dv && x_dr) begin
                m_full = 1;
                m_rs1 = v.rs1; m_r1 = v.r1; m_rs2 = v.rs2; m_r2 = v.r2;
                m_rd = v.rd; m_wr = v.wr; m_pay = v.pay;
            end else if (x_issue) begin
                m_full = 0;
            end
        end
    endtask

    // One clock: drive, sample mid-cycle, check, advance model at the edge
    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        rst_i = v.rst; dec_valid_i = v.dv;
        dec_rs1_i = v.rs1; dec_rd1_i = v.r1; dec_rs2_i = v.rs2; dec_rd2_i = v.r2;
        dec_rd_i = v.rd; dec_wr_i = v.wr; dec_payload_i = v.pay;
        iss_ready_i = v.ir; wb_valid_i = v.wbv; wb_rd_i = v.wbrd; flush_i = v.fl;
        #4;
        model_eval(v);
        chk({tag, ".dec_ready"}, dec_ready_o, x_dr);
        if (!v.rst) begin
            chk({tag, ".iss_valid"}, iss_valid_o, x_iv);
            chk({tag, ".stall"}, stall_o, x_st);
            chk({tag, ".sb_busy"}, sb_busy_o, m_busy != 0);
            chk({tag, ".fields"},
                {iss_rs1_o, iss_rd1_o, iss_rs2_o, iss_rd2_o, iss_rd_o, iss_wr_o, iss_payload_o},
                {m_rs1, m_r1, m_rs2, m_r2, m_rd, m_wr, m_pay});
        end
        if (use_tbl) begin
            chk({tag, ".tbl_dr"}, dec_ready_o, v.e_dr);
            if (!v.rst) begin
                chk({tag, ".tbl_iv"}, iss_valid_o, v.e_iv);
                chk({tag, ".tbl_st"}, stall_o, v.e_st);
                chk({tag, ".tbl_sb"}, sb_busy_o, v.e_sb);
            end
        end
        @(posedge clk_i);
        model_update(v);
        #1;
    endtask

    function automatic vec_t mk(bit dv, bit [4:0] rs1, bit r1, bit [4:0] rd, bit wr,
                                bit wbv, bit [4:0] wbrd, bit iv, bit dr, bit st, bit sb);
        vec_t v;
        v = '{default: 0};
        v.dv = dv; v.rs1 = rs1; v.r1 = r1; v.rd = rd; v.wr = wr; v.ir = 1'b1;
        v.wbv = wbv; v.wbrd = wbrd; v.pay = {32'hC0DE_0000, 22'd0, rs1, rd};
        v.e_iv = iv; v.e_dr = dr; v.e_st = st; v.e_sb = sb;
        return v;
    endfunction

    function automatic vec_t rstv();
        vec_t v;
        v = '{default: 0};
        v.rst = 1'b1;
        return v;
    endfunction

    vec_t tbl[16];
    vec_t seq[$];
    vec_t v;

    initial begin
        // Capacity / independent back-to-back / ignored writeback / x0 scenario
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,    0,   1,    0,    0);
        tbl[1]  = mk(1, 0, 0, 1, 1, 0, 0,    0,   1,    0,    0);
        tbl[2]  = mk(1, 0, 0, 2, 1, 0, 0,    1,   1,    0,    0);
        tbl[3]  = mk(1, 0, 0, 3, 1, 0, 0,    1,   1,    0,    1);
        tbl[4]  = mk(1, 0, 0, 4, 1, 0, 0,    1,   1,    0,    1);
        tbl[5]  = mk(1, 0, 0, 6, 1, 0, 0,    1,   1,    0,    1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,    0,   0,    1,    1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,    0,   0,    1,    1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 7,    0,   0,    1,    1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,    0,   0,    1,    1);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 2,    BYP, BYP,  !BYP, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,    !BYP, 1,   0,    1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,    0,   1,    0,    1);
        tbl[13] = mk(1, 0, 0, 0, 1, 0, 0,    0,   1,    0,    1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,    1,   1,    0,    1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,    0,   1,    0,    1);

        @(posedge clk_i);
        #1;
        step(rstv(), 1, "reset0");
        step(rstv(), 1, "reset1");
        for (int i = 0; i < 16; i++) begin
            step(tbl[i], 1, $sformatf("cap[%0d]", i));
        end

        // RAW on x5 released by writeback, then flush of a stalled entry, then reset mid-stall
        seq.push_back(rstv());
        seq.push_back(mk(1, 0, 0, 5, 1, 0, 0,    0,   1,    0,    0));
        seq.push_back(mk(1, 5, 1, 0, 0, 0, 0,    1,   1,    0,    0));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0,   0,    1,    1));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0,   0,    1,    1));
        seq.push_back(mk(0, 0, 0, 0, 0, 1, 5,    BYP, BYP,  !BYP, 1));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    !BYP, 1,   0,    0));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0,   1,    0,    0));
        seq.push_back(mk(1, 0, 0, 5, 1, 0, 0,    0,   1,    0,    0));
        seq.push_back(mk(1, 5, 1, 0, 0, 0, 0,    1,   1,    0,    0));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0,   0,    1,    1));
        v = mk(1, 0, 0, 9, 1, 0, 0,              0,   0,    0,    1);
        v.fl = 1'b1;
        seq.push_back(v);
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0,   1,    0,    1));
        seq.push_back(mk(1, 5, 1, 0, 0, 0, 0,    0,   1,    0,    1));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0,   0,    1,    1));
        seq.push_back(rstv());
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0,   1,    0,    0));
        seq.push_back(mk(0, 0, 0, 0, 0, 1, 5,    0,   1,    0,    0));
        foreach (seq[i]) begin
            step(seq[i], 1, $sformatf("seq[%0d]", i));
        end

        // Randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            v = '{default: 0};
            v.rst  = ($urandom_range(0, 299) == 0);
            v.dv   = ($urandom_range(0, 3) != 0);
            v.rs1  = 5'($urandom_range(0, 7));
            v.r1   = 1'($urandom_range(0, 1));
            v.rs2  = 5'($urandom_range(0, 7));
            v.r2   = 1'($urandom_range(0, 1));
            v.rd   = 5'($urandom_range(0, 7));
            v.wr   = ($urandom_range(0, 3) != 0);
            v.pay  = {$urandom, $urandom};
            v.ir   = ($urandom_range(0, 3) != 0);
            v.wbv  = ($urandom_range(0, 2) == 0);
            v.wbrd = 5'($urandom_range(0, 7));
            v.fl   = ($urandom_range(0, 19) == 0);
            step(v, 0, $sformatf("rnd[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
